// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column-at-a-time drive, per-key frame debounce,
// debounced key bitmap and a single-cycle event for the lowest newly pressed key.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_CYCLES    = 100000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int HEX_MAP        = 1,
    localparam int KEYS          = ROWS * COLS,
    localparam int CODE_W        = ($clog2(KEYS) > 4) ? $clog2(KEYS) : 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [KEYS-1:0]   key_state,
    output logic              key_down,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code
);
    localparam int CNT_W = $clog2(SCAN_CYCLES);
    localparam int COL_W = $clog2(COLS);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int IDX_W = $clog2(KEYS);
    localparam logic [COLS-1:0]  MSB_ONE  = {1'b1, {(COLS-1){1'b0}}};
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [2:0] {DRIVE, SETTLE, SAMPLE, HOLD, UPDATE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [COL_W-1:0] col_idx;
    logic [ROWS-1:0]  row_meta;
    logic [ROWS-1:0]  row_sync;
    logic [KEYS-1:0]  raw;
    logic [DEB_W-1:0] deb_cnt  [KEYS];
    logic [DEB_W-1:0] deb_next [KEYS];
    logic [KEYS-1:0]  state_next;
    logic [KEYS-1:0]  rose;
    logic [IDX_W-1:0] first_idx;

    function automatic logic [CODE_W-1:0] code_of(input logic [IDX_W-1:0] k);
        logic [CODE_W-1:0] code;
        code = CODE_W'(k);
        if (HEX_MAP != 0) begin
            case (int'(k))
                0:  code = CODE_W'(4'h1);
                1:  code = CODE_W'(4'h2);
                2:  code = CODE_W'(4'h3);
                3:  code = CODE_W'(4'hA);
                4:  code = CODE_W'(4'h4);
                5:  code = CODE_W'(4'h5);
                6:  code = CODE_W'(4'h6);
                7:  code = CODE_W'(4'hB);
                8:  code = CODE_W'(4'h7);
                9:  code = CODE_W'(4'h8);
                10: code = CODE_W'(4'h9);
                11: code = CODE_W'(4'hC);
                12: code = CODE_W'(4'h0);
                13: code = CODE_W'(4'hF);
                14: code = CODE_W'(4'hE);
                15: code = CODE_W'(4'hD);
                default: code = CODE_W'(k);
            endcase
        end
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // A key toggles on the frame where its disagreement count reaches DEBOUNCE_SCANS.
    genvar gi;
    generate
        for (gi = 0; gi < KEYS; gi++) begin : g_deb
            assign state_next[gi] = (raw[gi] != key_state[gi] && deb_cnt[gi] == DEB_LAST)
                                    ? raw[gi] : key_state[gi];
            assign deb_next[gi]   = (raw[gi] == key_state[gi] || deb_cnt[gi] == DEB_LAST)
                                    ? '0 : deb_cnt[gi] + 1'b1;
        end
    endgenerate

    assign rose = state_next & ~key_state;

    always_comb begin
        first_idx = '0;
        for (int k = KEYS - 1; k >= 0; k--) begin
            if (rose[k]) first_idx = IDX_W'(k);
        end
    end

    // The last column's final held cycle doubles as UPDATE, so every column stays
    // driven for exactly SCAN_CYCLES and col is released only during DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRIVE;
            cnt       <= '0;
            col_idx   <= '0;
            col       <= '1;
            raw       <= '0;
            key_state <= '0;
            key_down  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            for (int k = 0; k < KEYS; k++) deb_cnt[k] <= '0;
        end else begin
            key_valid <= 1'b0;
            key_down  <= |key_state;
            case (state)
                DRIVE: begin
                    col   <= ~(MSB_ONE >> col_idx);
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (col_idx == COL_W'(c)) raw[r*COLS+c] <= ~row_sync[ROWS-1-r];
                        end
                    end
                    cnt   <= cnt + 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (col_idx == LAST_COL) begin
                        if (cnt >= CNT_W'(SCAN_CYCLES - 2)) state <= UPDATE;
                        else cnt <= cnt + 1'b1;
                    end else if (cnt >= CNT_W'(SCAN_CYCLES - 1)) begin
                        col     <= '1;
                        col_idx <= col_idx + 1'b1;
                        state   <= DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    col       <= '1;
                    col_idx   <= '0;
                    state     <= DRIVE;
                    key_state <= state_next;
                    for (int k = 0; k < KEYS; k++) deb_cnt[k] <= deb_next[k];
                    if (|rose) begin
                        key_valid <= 1'b1;
                        key_code  <= code_of(first_idx);
                    end
                end
                default: state <= DRIVE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench: a 4x4 hex keypad and a 2x3 linear keypad driven by a key-matrix model,
// checked frame by frame against a per-key debounce reference model.
module tb_keypad_scanner;
    localparam int SCAN = 16;
    localparam int DEB  = 2;
    localparam int FA   = 4 * SCAN + 4;
    localparam int FB   = 3 * SCAN + 3;

    logic        clk;
    logic        rst_a, rst_b;
    logic [3:0]  row_a, col_a, kc_a;
    logic [15:0] ks_a, press_a;
    logic        kd_a, kv_a;
    logic [1:0]  row_b;
    logic [2:0]  col_b;
    logic [5:0]  ks_b, press_b;
    logic [3:0]  kc_b;
    logic        kd_b, kv_b;

    int tests = 0;
    int fails = 0;
    int t_a, t_b;
    int pulses_a = 0, pulses_b = 0, exp_pulses_a = 0, exp_pulses_b = 0;
    logic [15:0] m_state;
    int          m_cnt [16];
    logic [3:0]  m_code;
    logic        snap_kv;
    logic [3:0]  snap_kc;
    logic [3:0]  hex_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_CYCLES(SCAN), .SETTLE_CYCLES(4),
                     .DEBOUNCE_SCANS(DEB), .HEX_MAP(1)) dut_a (
        .clk(clk), .rst(rst_a), .row(row_a), .col(col_a), .key_state(ks_a),
        .key_down(kd_a), .key_valid(kv_a), .key_code(kc_a));

    keypad_scanner #(.ROWS(2), .COLS(3), .SCAN_CYCLES(SCAN), .SETTLE_CYCLES(4),
                     .DEBOUNCE_SCANS(DEB), .HEX_MAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .row(row_b), .col(col_b), .key_state(ks_b),
        .key_down(kd_b), .key_valid(kv_b), .key_code(kc_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_a = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_a[r*4+c] && !col_a[3-c]) row_a[3-r] = 1'b0;
        row_b = '1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                if (press_b[r*3+c] && !col_b[2-c]) row_b[1-r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected column pattern t cycles after reset release: each column low for
    // SCAN cycles, then one all-high cycle.
    function automatic logic [31:0] col_exp(input int t, input int n);
        int p, c, o;
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        if (t == 0) return mask;
        p = (t - 1) % (n * (SCAN + 1));
        c = p / (SCAN + 1);
        o = p % (SCAN + 1);
        if (o == SCAN) return mask;
        return mask & ~(32'd1 << (n - 1 - c));
    endfunction

    always @(posedge clk or posedge rst_a) if (rst_a) t_a <= 0; else t_a <= t_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) t_b <= 0; else t_b <= t_b + 1;

    always @(negedge clk) begin
        check("col_a", 32'(col_a), col_exp(rst_a ? 0 : t_a, 4));
        check("col_b", 32'(col_b), col_exp(rst_b ? 0 : t_b, 3));
        if (kv_a) pulses_a++;
        if (kv_b) pulses_b++;
    end

    function automatic void model_reset();
        m_state = '0;
        m_code  = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    endfunction

    // One frame of per-key debounce; returns the lowest key that became pressed, or -1.
    function automatic int model_step(input logic [15:0] press, input int n);
        int ev = -1;
        for (int k = 0; k < n; k++) begin
            if (press[k] !== m_state[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == DEB) begin
                    m_state[k] = press[k];
                    m_cnt[k] = 0;
                    if (press[k] && ev < 0) ev = k;
                end
            end else begin
                m_cnt[k] = 0;
            end
        end
        return ev;
    endfunction

    task automatic frame_a(input logic [15:0] press);
        int ev;
        press_a = press;
        repeat (FA - 1) @(posedge clk);
        #1;
        ev = model_step(press, 16);
        if (ev >= 0) begin
            m_code = hex_tab[ev];
            exp_pulses_a++;
        end
        snap_kv = kv_a;
        snap_kc = kc_a;
        $display("[TB] A frame press=%04h kv=%0b code=%0h state=%04h", press, kv_a, kc_a, ks_a);
        check("kv_a", 32'(kv_a), 32'(ev >= 0));
        check("kc_a", 32'(kc_a), 32'(m_code));
        check("ks_a", 32'(ks_a), 32'(m_state));
        @(posedge clk);
        #1;
        check("kv_a_one_cycle", 32'(kv_a), 32'd0);
        check("kd_a", 32'(kd_a), 32'(|m_state));
    endtask

    task automatic frame_b(input logic [5:0] press);
        int ev;
        press_b = press;
        repeat (FB - 1) @(posedge clk);
        #1;
        ev = model_step({10'd0, press}, 6);
        if (ev >= 0) begin
            m_code = 4'(ev);
            exp_pulses_b++;
        end
        snap_kv = kv_b;
        snap_kc = kc_b;
        $display("[TB] B frame press=%02h kv=%0b code=%0h state=%02h", press, kv_b, kc_b, ks_b);
        check("kv_b", 32'(kv_b), 32'(ev >= 0));
        check("kc_b", 32'(kc_b), 32'(m_code));
        check("ks_b", 32'(ks_b), 32'(m_state[5:0]));
        @(posedge clk);
        #1;
        check("kv_b_one_cycle", 32'(kv_b), 32'd0);
        check("kd_b", 32'(kd_b), 32'(|m_state[5:0]));
    endtask

    initial begin
        logic [15:0] rnd;
        logic [5:0]  rnd_b;
        rst_a = 1'b1;
        rst_b = 1'b1;
        press_a = '0;
        press_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_a), 32'hF);
        check("rst_state", 32'(ks_a), 32'd0);
        check("rst_outs", 32'({kd_a, kv_a, kc_a}), 32'd0);
        rst_a = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) frame_a(16'h0000);
        check("idle_no_pulse", 32'(pulses_a), 32'd0);

        frame_a(16'h0040);
        check("r1c2_not_yet", 32'(snap_kv), 32'd0);
        frame_a(16'h0040);
        check("r1c2_valid", 32'(snap_kv), 32'd1);
        check("r1c2_code", 32'(snap_kc), 32'h6);
        check("r1c2_bit", 32'(ks_a[6]), 32'd1);
        frame_a(16'h0040);
        check("r1c2_single", 32'(snap_kv), 32'd0);
        repeat (2) frame_a(16'h0000);

        frame_a(16'h2000);
        frame_a(16'h0000);
        check("glitch_state", 32'(ks_a), 32'd0);
        check("glitch_no_ev", 32'(snap_kv), 32'd0);

        frame_a(16'h0801);
        frame_a(16'h0801);
        check("dual_code", 32'(snap_kc), 32'h1);
        check("dual_state", 32'(ks_a), 32'h0801);
        frame_a(16'h0000);
        frame_a(16'h0000);
        check("dual_release", 32'(ks_a), 32'd0);
        check("release_no_ev", 32'(snap_kv), 32'd0);

        rnd = '0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) rnd = 16'($urandom & $urandom & $urandom);
            frame_a(rnd);
        end
        repeat (2) frame_a(16'h0000);

        frame_a(16'h0020);
        repeat (2) @(posedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        check("midrst_col", 32'(col_a), 32'hF);
        check("midrst_state", 32'(ks_a), 32'd0);
        check("midrst_outs", 32'({kd_a, kv_a, kc_a}), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        frame_a(16'h0020);
        check("midrst_frame1", 32'(snap_kv), 32'd0);
        frame_a(16'h0020);
        check("midrst_frame2", 32'(snap_kv), 32'd1);
        check("midrst_code", 32'(snap_kc), 32'h5);
        check("pulses_a", 32'(pulses_a), 32'(exp_pulses_a));

        rst_a = 1'b1;
        press_a = '0;
        model_reset();
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        frame_b(6'b100000);
        frame_b(6'b100000);
        check("b_code5", 32'(snap_kc), 32'h5);
        check("b_valid", 32'(snap_kv), 32'd1);
        rnd_b = '0;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) rnd_b = 6'($urandom & $urandom);
            frame_b(rnd_b);
        end
        repeat (2) frame_b(6'b000000);
        check("pulses_b", 32'(pulses_b), 32'(exp_pulses_b));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
